// File: rtl/uart_dft_pkg.sv
// Shared opcodes, response bytes and FSM state encoding for the UART/DFT command path.
package uart_dft_pkg;

  typedef logic [7:0] byte_t;

  localparam byte_t CMD_LED_ON  = 8'hA1;
  localparam byte_t CMD_LED_OFF = 8'hA0;
  localparam byte_t CMD_SCAN    = 8'hB0;
  localparam byte_t CMD_STATUS  = 8'hC0;

  localparam byte_t RSP_ACK = 8'h55;
  localparam byte_t RSP_NAK = 8'hEE;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_GET_ARG = 3'd1;
  localparam logic [2:0] ST_SHIFT   = 3'd2;
  localparam logic [2:0] ST_RESP    = 3'd3;
  localparam logic [2:0] ST_WAIT_TX = 3'd4;

endpackage

// File: rtl/scan_shift_seq.sv
// Scan shift sequencer: drives scan_enable/scan_in for SCAN_LEN cycles and captures scan_out LSB first.
module scan_shift_seq
  import uart_dft_pkg::*;
#(
  parameter int SCAN_LEN = 8
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  start,
  input  byte_t arg,
  input  logic  scan_out,
  output logic  scan_enable,
  output logic  scan_in,
  output logic  done,
  output byte_t capture
);

  localparam logic [2:0] LAST_IDX = 3'(SCAN_LEN - 1);

  logic [2:0] idx;
  byte_t      arg_r;
  byte_t      cap_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_enable <= 1'b0;
      scan_in     <= 1'b0;
      idx         <= 3'd0;
      arg_r       <= 8'h00;
      cap_r       <= 8'h00;
    end else if (start) begin
      scan_enable <= 1'b1;
      scan_in     <= arg[0];
      idx         <= 3'd0;
      arg_r       <= arg;
      cap_r       <= 8'h00;
    end else if (scan_enable) begin
      cap_r[idx] <= scan_out;
      if (idx == LAST_IDX) begin
        scan_enable <= 1'b0;
        scan_in     <= 1'b0;
      end else begin
        idx     <= idx + 3'd1;
        scan_in <= arg_r[idx + 3'd1];
      end
    end
  end

  // Final capture bit is merged combinationally so the controller can load it on the last shift edge.
  assign done = scan_enable && (idx == LAST_IDX);

  always_comb begin
    capture      = cap_r;
    capture[idx] = scan_out;
  end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// UART command controller: opcode decode, scan argument timeout, TX response scheduling, error tracking.
// Optional status opcode and drop counter enabled by UART_CMD_STATUS_EN.
//
// state      | meaning
// IDLE       | waiting for an opcode byte
// GET_ARG    | waiting for the scan argument byte, timeout running
// SHIFT      | scan sequencer shifting argument in / capture out
// RESP       | response byte loaded, waiting for TX to be free
// WAIT_TX    | tx_start issued, waiting for tx_busy to rise then fall
module uart_cmd_ctrl
  import uart_dft_pkg::*;
#(
  parameter int SCAN_LEN    = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  output logic       led,
  output logic       scan_enable,
  output logic       scan_in,
  input  logic       scan_out,
  output logic       busy,
  output logic       err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [2:0]    state;
  logic [TW-1:0] to_cnt;
  logic          seen_busy;
  logic          scan_start;
  logic          scan_done;
  byte_t         capture;
  logic          drop;
  byte_t         status_byte;
  logic          status_ok;

  assign busy       = (state != ST_IDLE);
  assign scan_start = (state == ST_GET_ARG) && rx_valid;
  assign drop       = rx_valid &&
                      ((state == ST_SHIFT) || (state == ST_RESP) || (state == ST_WAIT_TX));

  scan_shift_seq #(.SCAN_LEN(SCAN_LEN)) u_scan (
    .clk         (clk),
    .rst         (rst),
    .start       (scan_start),
    .arg         (rx_data),
    .scan_out    (scan_out),
    .scan_enable (scan_enable),
    .scan_in     (scan_in),
    .done        (scan_done),
    .capture     (capture)
  );

`ifdef UART_CMD_STATUS_EN
  logic [3:0] drop_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= 4'd0;
    end else if (drop && (drop_cnt != 4'hF)) begin
      drop_cnt <= drop_cnt + 4'd1;
    end
  end

  assign status_byte = {led, err, 2'b00, drop_cnt};
  assign status_ok   = 1'b1;
`else
  assign status_byte = RSP_NAK;
  assign status_ok   = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      led       <= 1'b0;
      err       <= 1'b0;
      tx_data   <= 8'h00;
      tx_start  <= 1'b0;
      to_cnt    <= '0;
      seen_busy <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      if (drop) err <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (rx_valid) begin
            state <= ST_RESP;
            case (rx_data)
              CMD_LED_ON: begin
                led     <= 1'b1;
                tx_data <= RSP_ACK;
              end
              CMD_LED_OFF: begin
                led     <= 1'b0;
                tx_data <= RSP_ACK;
              end
              CMD_SCAN: begin
                state  <= ST_GET_ARG;
                to_cnt <= TW'(TIMEOUT_CYC - 1);
              end
              default: begin
                if ((rx_data == CMD_STATUS) && status_ok) begin
                  tx_data <= status_byte;
                end else begin
                  tx_data <= RSP_NAK;
                  err     <= 1'b1;
                end
              end
            endcase
          end
        end

        // An argument arriving on the expiry cycle takes priority over the timeout.
        ST_GET_ARG: begin
          if (rx_valid) begin
            state <= ST_SHIFT;
          end else if (to_cnt == '0) begin
            err     <= 1'b1;
            tx_data <= RSP_NAK;
            state   <= ST_RESP;
          end else begin
            to_cnt <= to_cnt - TW'(1);
          end
        end

        ST_SHIFT: begin
          if (scan_done) begin
            tx_data <= capture;
            state   <= ST_RESP;
          end
        end

        ST_RESP: begin
          if (!tx_busy) begin
            tx_start  <= 1'b1;
            seen_busy <= 1'b0;
            state     <= ST_WAIT_TX;
          end
        end

        ST_WAIT_TX: begin
          if (tx_busy) begin
            seen_busy <= 1'b1;
          end else if (seen_busy) begin
            state <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
